// File: rtl/cz80_registers.sv
// Z80 register file: banked BC/DE/HL with EXX / EX DE,HL renaming,
// shared SP/IX/IY, registered 8-bit operands and a 16-bit pair output.
module cz80_registers #(
  parameter logic [15:0] RESET_VALUE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cen,
  input  logic [2:0]  sel_a,
  input  logic        hi_a,
  input  logic [2:0]  sel_b,
  input  logic        hi_b,
  input  logic [2:0]  sel_w,
  input  logic        we_h,
  input  logic        we_l,
  input  logic [15:0] di,
  input  logic        exx,
  input  logic        ex_dehl,
  output logic [7:0]  busa,
  output logic [7:0]  busb,
  output logic [15:0] pair_a
);

  localparam logic [3:0] NONE = 4'd15;

  logic [15:0] rf_q [9];
  logic [15:0] rf_d [9];
  logic        bank_q, bank_d;
  logic [1:0]  swap_q, swap_d;
  logic [7:0]  busa_q, busa_d;
  logic [7:0]  busb_q, busb_d;
  logic [15:0] pair_a_q, pair_a_d;

  logic        cur_swap;
  logic [3:0]  pa, pb, pw;
  logic [15:0] va, vb;

  // Physical slots: bank*3 + {BC,DE,HL}, then SP=6, IX=7, IY=8.
  function automatic logic [3:0] phys(
    input logic [2:0] sel,
    input logic       bank,
    input logic       swap
  );
    logic [3:0] base;
    base = bank ? 4'd3 : 4'd0;
    unique case (sel)
      3'd0:    phys = base;
      3'd1:    phys = swap ? base + 4'd2 : base + 4'd1;
      3'd2:    phys = swap ? base + 4'd1 : base + 4'd2;
      3'd3:    phys = 4'd6;
      3'd4:    phys = 4'd7;
      3'd5:    phys = 4'd8;
      default: phys = NONE;
    endcase
  endfunction

  always_comb begin
    cur_swap = bank_q ? swap_q[1] : swap_q[0];
    pa = phys(sel_a, bank_q, cur_swap);
    pb = phys(sel_b, bank_q, cur_swap);
    pw = phys(sel_w, bank_q, cur_swap);
  end

  // Bypass compares physical slots, so renaming in this cycle is harmless.
  always_comb begin
    va = 16'hFFFF;
    if (pa != NONE) begin
      va = rf_q[pa];
      if (pw == pa) begin
        if (we_h) va[15:8] = di[15:8];
        if (we_l) va[7:0]  = di[7:0];
      end
    end
    vb = 16'hFFFF;
    if (pb != NONE) begin
      vb = rf_q[pb];
      if (pw == pb) begin
        if (we_h) vb[15:8] = di[15:8];
        if (we_l) vb[7:0]  = di[7:0];
      end
    end
  end

  always_comb begin
    rf_d     = rf_q;
    bank_d   = bank_q;
    swap_d   = swap_q;
    busa_d   = busa_q;
    busb_d   = busb_q;
    pair_a_d = pair_a_q;
    if (cen) begin
      if (pw != NONE) begin
        if (we_h) rf_d[pw][15:8] = di[15:8];
        if (we_l) rf_d[pw][7:0]  = di[7:0];
      end
      if (ex_dehl) swap_d[bank_q] = ~swap_q[bank_q];
      if (exx) bank_d = ~bank_q;
      busa_d   = hi_a ? va[15:8] : va[7:0];
      busb_d   = hi_b ? vb[15:8] : vb[7:0];
      pair_a_d = va;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) rf_q[i] <= RESET_VALUE;
      bank_q   <= 1'b0;
      swap_q   <= 2'b00;
      busa_q   <= 8'hFF;
      busb_q   <= 8'hFF;
      pair_a_q <= 16'hFFFF;
    end else begin
      rf_q     <= rf_d;
      bank_q   <= bank_d;
      swap_q   <= swap_d;
      busa_q   <= busa_d;
      busb_q   <= busb_d;
      pair_a_q <= pair_a_d;
    end
  end

  assign busa   = busa_q;
  assign busb   = busb_q;
  assign pair_a = pair_a_q;

endmodule

// File: tb/tb_cz80_registers.sv
// Directed bench for cz80_registers: reset, writes, bypass,
// EXX / EX DE,HL renaming, clock enable and reset priority.
module tb_cz80_registers;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cen;
  logic [2:0]  sel_a, sel_b, sel_w;
  logic        hi_a, hi_b, we_h, we_l;
  logic [15:0] di;
  logic        exx, ex_dehl;
  logic [7:0]  busa, busb;
  logic [15:0] pair_a;

  int n_chk = 0;
  int n_fail = 0;

  cz80_registers #(.RESET_VALUE(16'hFFFF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .sel_a   (sel_a),
    .hi_a    (hi_a),
    .sel_b   (sel_b),
    .hi_b    (hi_b),
    .sel_w   (sel_w),
    .we_h    (we_h),
    .we_l    (we_l),
    .di      (di),
    .exx     (exx),
    .ex_dehl (ex_dehl),
    .busa    (busa),
    .busb    (busb),
    .pair_a  (pair_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    we_h = 0; we_l = 0; exx = 0; ex_dehl = 0;
  endtask

  task automatic wr(input logic [2:0] s, input logic [15:0] d);
    sel_w = s; di = d; we_h = 1; we_l = 1;
    tick();
    quiet();
  endtask

  task automatic rd(input string tag, input logic [2:0] s,
                    input logic [15:0] exp);
    sel_a = s; hi_a = 0;
    tick();
    chk(tag, pair_a, exp);
  endtask

  task automatic pulse(input logic x, input logic e);
    exx = x; ex_dehl = e;
    tick();
    quiet();
  endtask

  initial begin
    reset_n = 0; cen = 1; sel_a = 0; sel_b = 0; sel_w = 7;
    hi_a = 0; hi_b = 0; di = 0;
    quiet();
    tick();
    tick();
    chk("rst_busa", {8'h0, busa}, 16'h00FF);
    chk("rst_pair", pair_a, 16'hFFFF);
    reset_n = 1; sel_a = 2; hi_a = 1; sel_b = 3; hi_b = 0;
    tick();
    chk("rel_busa", {8'h0, busa}, 16'h00FF);
    chk("rel_busb", {8'h0, busb}, 16'h00FF);
    chk("rel_pair", pair_a, 16'hFFFF);

    wr(0, 16'h1234);
    sel_a = 0; hi_a = 1; sel_b = 0; hi_b = 0;
    tick();
    chk("bc_hi", {8'h0, busa}, 16'h0012);
    chk("bc_lo", {8'h0, busb}, 16'h0034);
    chk("bc_pair", pair_a, 16'h1234);

    sel_w = 0; di = 16'hAA55; we_h = 1;
    tick();
    quiet();
    chk("weh_byp", pair_a, 16'hAA34);
    tick();
    chk("weh_bc", pair_a, 16'hAA34);
    chk("weh_lo", {8'h0, busb}, 16'h0034);

    sel_a = 4; hi_a = 0; sel_w = 4; di = 16'hBEEF; we_h = 1; we_l = 1;
    tick();
    quiet();
    chk("byp_busa", {8'h0, busa}, 16'h00EF);
    chk("byp_pair", pair_a, 16'hBEEF);
    sel_a = 7; sel_w = 7; di = 16'h0000; we_h = 1; we_l = 1;
    tick();
    quiet();
    chk("rsv_read", pair_a, 16'hFFFF);

    wr(2, 16'h1111);
    pulse(1, 0);
    wr(2, 16'h2222);
    pulse(1, 0);
    rd("exx_main_hl", 2, 16'h1111);
    pulse(1, 0);
    rd("exx_alt_hl", 2, 16'h2222);
    rd("exx_ix", 4, 16'hBEEF);
    rd("exx_sp", 3, 16'hFFFF);

    pulse(1, 0);
    wr(1, 16'h0D0E);
    wr(2, 16'h0408);
    pulse(0, 1);
    rd("swap_de", 1, 16'h0408);
    rd("swap_hl", 2, 16'h0D0E);
    pulse(1, 0);
    rd("alt_de", 1, 16'hFFFF);
    rd("alt_hl", 2, 16'h2222);
    pulse(1, 0);
    pulse(1, 1);
    rd("both_alt_de", 1, 16'hFFFF);
    pulse(1, 0);
    rd("unswap_de", 1, 16'h0D0E);
    rd("unswap_hl", 2, 16'h0408);

    sel_w = 0; di = 16'h5A5A; we_h = 1; we_l = 1; exx = 1;
    tick();
    quiet();
    rd("wexx_alt_bc", 0, 16'hFFFF);
    pulse(1, 0);
    rd("wexx_main_bc", 0, 16'h5A5A);

    cen = 0; sel_a = 2; sel_w = 0; di = 16'h0000;
    we_h = 1; we_l = 1; exx = 1;
    tick();
    chk("cen_hold", pair_a, 16'h5A5A);
    quiet();
    cen = 1;
    rd("cen_bc", 0, 16'h5A5A);
    rd("cen_hl", 2, 16'h0408);

    reset_n = 0; cen = 0; exx = 1;
    tick();
    chk("rp_busa", {8'h0, busa}, 16'h00FF);
    chk("rp_pair", pair_a, 16'hFFFF);
    reset_n = 1; cen = 1;
    quiet();
    rd("rp_bc", 0, 16'hFFFF);
    rd("rp_de", 1, 16'hFFFF);
    wr(1, 16'h3333);
    rd("rp_noswap", 2, 16'hFFFF);
    pulse(1, 0);
    rd("rp_alt", 1, 16'hFFFF);
    pulse(1, 0);
    rd("rp_main", 1, 16'h3333);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cz80_registers.md
Name: cz80_registers

Overview:
- Z80 general register file, directly upstream of cz80_alu.
- Holds the main and alternate BC/DE/HL banks plus shared SP/IX/IY.
- Supplies the registered 8-bit operands that drive cz80_alu busa/busb, plus a 16-bit address/arith16 operand.
- Accepts 8-bit and 16-bit write-back, and executes EXX and EX DE,HL as register-renaming operations (no data movement).

Parameters:
- RESET_VALUE, 16'hFFFF: value loaded into every register on reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- cen  in  1  clock enable; when 0 all state and outputs hold
- sel_a  in  3  busa pair select: 0 BC, 1 DE, 2 HL, 3 SP, 4 IX, 5 IY, 6/7 reserved (read 16'hFFFF)
- hi_a  in  1  busa byte: 1 = high (B/D/H/SPh/IXh/IYh), 0 = low
- sel_b  in  3  busb pair select, same encoding
- hi_b  in  1  busb byte select
- sel_w  in  3  write pair select, same encoding; 6/7 writes are ignored
- we_h  in  1  write di[15:8] to high byte of sel_w
- we_l  in  1  write di[7:0] to low byte of sel_w
- di  in  16  write data
- exx  in  1  toggle BC/DE/HL bank
- ex_dehl  in  1  toggle DE/HL swap flag of the current bank
- busa  out  8  registered operand A
- busb  out  8  registered operand B
- pair_a  out  16  registered full pair selected by sel_a

Behaviour:
- State:
  - Two banks, each with BC, DE and HL.
  - Shared SP, IX, IY.
  - bank flag: 0 = main.
  - Per-bank swap flags: swap0, swap1.
- Logical-to-physical mapping:
  - sel 1 (DE) maps to physical HL of the active bank when that bank's swap flag is 1.
  - sel 2 (HL) maps to physical DE under the same condition.
  - BC, SP, IX, IY are unaffected by bank and swap flags.
- Reset: when reset_n=0 at a clk edge, regardless of cen:
  - every register = RESET_VALUE;
  - bank=0, swap0=swap1=0;
  - busa=busb=8'hFF, pair_a=16'hFFFF.
- All updates occur only at clk edges with cen=1.
- Writes:
  - we_h and we_l are independent; both set = 16-bit write.
  - Target is resolved with the bank/swap state at the start of the cycle (pre-toggle).
- exx=1: bank <= ~bank.
- ex_dehl=1: swap flag of the bank active at the start of the cycle is inverted.
- exx and ex_dehl in the same cycle:
  - the ex_dehl toggle applies to the old bank;
  - then the bank switches.
- Write together with exx or ex_dehl in the same cycle: the write lands in the pre-toggle physical register.
- Read latency is 1 cycle: busa/busb/pair_a register the value selected at the edge.
- Write-through bypass: if a read in the same cycle targets a byte being written, the registered output takes the new di byte.
  - The bypass compares physical registers, so it holds even when the read mapping changes in the same cycle.
- Read mapping in a cycle uses the pre-toggle state; a toggle affects reads from the next cycle on.
- Reserved selects 6/7 read 16'hFFFF and never bypass.
- cen=0: writes, toggles and output registers all hold.
- Reset asserted mid-sequence (for example in a cycle with pending exx) wins over every other input.

Test Plan:
- Reset, RESET_VALUE default:
  - Stimulus: reset_n=0 for 2 cycles, then sel_a=2, hi_a=1, sel_b=3, hi_b=0.
  - Required: busa=8'hFF, busb=8'hFF, pair_a=16'hFFFF one cycle after release.
- 16-bit write and readback:
  - Stimulus: write sel_w=0, di=16'h1234, we_h=we_l=1.
  - Required: next cycle with sel_a=0, hi_a=1 → busa=8'h12; sel_b=0, hi_b=0 → busb=8'h34; pair_a=16'h1234.
  - Byte enables: we_h only with di=16'hAA55 → BC becomes 16'hAA34.
- Bypass:
  - Stimulus: same cycle write sel_w=4 (IX), di=16'hBEEF, and read sel_a=4, hi_a=0.
  - Required: busa=8'hEF next cycle, not the old IX low byte.
- EXX:
  - Stimulus: write HL=16'h1111, pulse exx, write HL=16'h2222, pulse exx.
  - Required: HL reads 16'h1111.
  - Stimulus: pulse exx again.
  - Required: HL reads 16'h2222; IX and SP unchanged throughout.
- EX DE,HL per bank:
  - Stimulus: DE=16'h0D0E, HL=16'h0408, pulse ex_dehl.
  - Required: DE reads 16'h0408, HL reads 16'h0D0E.
  - Stimulus: pulse exx.
  - Required: alternate bank is not swapped.
  - Stimulus: exx and ex_dehl in the same cycle.
  - Required: the main bank unswaps; main DE reads 16'h0D0E again afterwards.
- cen and reset priority:
  - Stimulus: cen=0 with we_h=we_l=1, exx=1.
  - Required: no state change and outputs held.
  - Stimulus: reset_n=0 with cen=0 and exx=1.
  - Required: full reset state, bank=0.
